mem_port_join: RTL and testbench

Joins the CPU datapath's separate instruction and data memory ports onto one shared word-wide memory port. The block sits directly downstream of the pipelined datapath. It serializes a pending data access and a pending instruction fetch: data first, then fetch. It buffers each returned word and raises `instr_mem_resp` and `data_mem_resp` together in a single cycle, so the datapath's combined stall condition clears exactly once per pipeline advance. Upstream of the block is the datapath; downstream is the memory or cache model.

---
 rtl/mem_port_join.sv | 156 +++++++++++++++
 tb/tb_mem_port_join.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_join.sv
// mem_port_join: serializes a pending data access and then an instruction fetch onto one
// shared memory port. Define MEM_JOIN_WDOG_EN to add the sticky response watchdog.
module mem_port_join #(
    parameter int WDOG_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_read,
    input  logic [31:0] instr_mem_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_mem_address,
    input  logic [31:0] data_mem_wdata,
    input  logic [3:0]  data_mbe,
    output logic [31:0] instr_mem_rdata,
    output logic        instr_mem_resp,
    output logic [31:0] data_mem_rdata,
    output logic        data_mem_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mbe,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        wdog_err
);
    // state | meaning
    // IDLE  | sample request ports, launch the first access
    // DATA  | captured load/store driven on the shared port
    // INSTR | captured fetch driven on the shared port
    // DONE  | pulse both responses in the same cycle
    typedef enum logic [1:0] {IDLE, DATA, INSTR, DONE} state_t;

    state_t      state;
    logic        need_d;
    logic        need_i;
    logic        is_write;
    logic [31:0] fetch_addr;
    logic        new_d;

    assign new_d = data_read | data_write;

    // The shared-port outputs double as the captured data request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            need_d          <= 1'b0;
            need_i          <= 1'b0;
            is_write        <= 1'b0;
            fetch_addr      <= 32'h0;
            instr_mem_rdata <= 32'h0;
            instr_mem_resp  <= 1'b0;
            data_mem_rdata  <= 32'h0;
            data_mem_resp   <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= 32'h0;
            mem_wdata       <= 32'h0;
            mem_mbe         <= 4'h0;
        end else begin
            instr_mem_resp <= 1'b0;
            data_mem_resp  <= 1'b0;
            case (state)
                IDLE: begin
                    need_d     <= new_d;
                    need_i     <= instr_read;
                    is_write   <= data_write;
                    fetch_addr <= instr_mem_address;
                    if (new_d) begin
                        state       <= DATA;
                        mem_write   <= data_write;
                        mem_read    <= ~data_write;
                        mem_address <= data_mem_address;
                        mem_wdata   <= data_write ? data_mem_wdata : 32'h0;
                        mem_mbe     <= data_write ? data_mbe : 4'hF;
                    end else if (instr_read) begin
                        state       <= INSTR;
                        mem_write   <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_address <= instr_mem_address;
                        mem_wdata   <= 32'h0;
                        mem_mbe     <= 4'hF;
                    end
                end
                DATA: begin
                    if (mem_resp) begin
                        if (!is_write) begin
                            data_mem_rdata <= mem_rdata;
                        end
                        if (need_i) begin
                            state       <= INSTR;
                            mem_write   <= 1'b0;
                            mem_read    <= 1'b1;
                            mem_address <= fetch_addr;
                            mem_wdata   <= 32'h0;
                            mem_mbe     <= 4'hF;
                        end else begin
                            state          <= DONE;
                            mem_write      <= 1'b0;
                            mem_read       <= 1'b0;
                            instr_mem_resp <= need_i;
                            data_mem_resp  <= need_d;
                        end
                    end
                end
                INSTR: begin
                    if (mem_resp) begin
                        instr_mem_rdata <= mem_rdata;
                        state           <= DONE;
                        mem_write       <= 1'b0;
                        mem_read        <= 1'b0;
                        instr_mem_resp  <= need_i;
                        data_mem_resp   <= need_d;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_JOIN_WDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES + 1);
    localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_CYCLES - 1);

    logic [CW-1:0] wdog_cnt;
    logic          waiting;

    assign waiting = ((state == DATA) || (state == INSTR)) && !mem_resp;

    // Held at zero outside a wait, so it restarts on every DATA/INSTR entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else if (!waiting) begin
            wdog_cnt <= '0;
        end else if (wdog_cnt == WDOG_LAST) begin
            wdog_err <= 1'b1;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end
`else
    logic unused_wdog_cfg;

    assign unused_wdog_cfg = (WDOG_CYCLES > 0);
    assign wdog_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_join.sv
// Bench for mem_port_join: latency-programmable memory responder plus a request-level
// reference model of the serialized data-then-fetch protocol.
module tb_mem_port_join;
    localparam int WDOG = 16;
`ifdef MEM_JOIN_WDOG_EN
    localparam logic WDOG_ON = 1'b1;
`else
    localparam logic WDOG_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  mbe;
        int          start;
        logic        stable;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_read = 1'b0;
    logic [31:0] instr_mem_address = 32'h0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_mem_address = 32'h0;
    logic [31:0] data_mem_wdata = 32'h0;
    logic [3:0]  data_mbe = 4'h0;
    logic [31:0] instr_mem_rdata;
    logic        instr_mem_resp;
    logic [31:0] data_mem_rdata;
    logic        data_mem_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_resp = 1'b0;
    logic        wdog_err;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_done_cyc = -10;
    int          exp_start = 0;
    logic [31:0] exp_ibuf = 32'h0;
    logic [31:0] exp_dbuf = 32'h0;

    int          lat_q[$];
    logic [31:0] rd_q[$];
    txn_t        log_q[$];
    logic        manual = 1'b0;
    logic        man_resp = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    logic        act = 1'b0;
    int          cnt = 0;
    int          cur_lat = 1;
    txn_t        cur;

    logic [136:0] all_out;
    assign all_out = {instr_mem_rdata, instr_mem_resp, data_mem_rdata, data_mem_resp, mem_read,
                      mem_write, mem_address, mem_wdata, mem_mbe, wdog_err};

    mem_port_join #(.WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst(rst),
        .instr_read(instr_read), .instr_mem_address(instr_mem_address),
        .data_read(data_read), .data_write(data_write),
        .data_mem_address(data_mem_address), .data_mem_wdata(data_mem_wdata), .data_mbe(data_mbe),
        .instr_mem_rdata(instr_mem_rdata), .instr_mem_resp(instr_mem_resp),
        .data_mem_rdata(data_mem_rdata), .data_mem_resp(data_mem_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_mbe(mem_mbe), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Memory model: each strobe dwell is one transaction answered after its queued latency.
    always @(negedge clk) begin
        if (manual) begin
            mem_resp  = man_resp;
            mem_rdata = man_rdata;
        end else begin
            mem_resp = 1'b0;
            if (mem_read || mem_write) begin
                if (!act) begin
                    act = 1'b1;
                    cnt = 0;
                    if (lat_q.size() > 0) cur_lat = lat_q.pop_front();
                    else cur_lat = 1;
                    cur.addr = mem_address; cur.rd = mem_read; cur.wr = mem_write;
                    cur.wdata = mem_wdata; cur.mbe = mem_mbe; cur.start = cyc; cur.stable = 1'b1;
                end else if ({mem_address, mem_read, mem_write, mem_wdata, mem_mbe} !==
                             {cur.addr, cur.rd, cur.wr, cur.wdata, cur.mbe}) begin
                    cur.stable = 1'b0;
                end
                cnt++;
                if (cnt >= cur_lat) begin
                    mem_resp = 1'b1;
                    if (mem_read && rd_q.size() > 0) mem_rdata = rd_q.pop_front();
                    else mem_rdata = mem_word(mem_address);
                    log_q.push_back(cur);
                    act = 1'b0;
                end
            end else begin
                act = 1'b0;
            end
        end
    end

    // Called just after a negedge. A group launched in the DONE cycle samples one edge later.
    task automatic drive_group(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be,
                               input int ld, input int li);
        exp_start = (cyc == last_done_cyc) ? cyc + 2 : cyc + 1;
        log_q.delete();
        if (dr || dw) lat_q.push_back(ld);
        if (ir) lat_q.push_back(li);
        instr_read = ir; instr_mem_address = ia;
        data_read = dr; data_write = dw; data_mem_address = da; data_mem_wdata = wd; data_mbe = be;
    endtask

    task automatic release_inputs();
        instr_read = 1'b0; data_read = 1'b0; data_write = 1'b0;
    endtask

    task automatic wait_done(output int rc, output logic ip, output logic dp,
                             output logic [31:0] ir, output logic [31:0] dr, output logic st);
        rc = -1; ip = 1'b0; dp = 1'b0; ir = 32'h0; dr = 32'h0; st = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (instr_mem_resp || data_mem_resp) begin
                rc = cyc; ip = instr_mem_resp; dp = data_mem_resp;
                ir = instr_mem_rdata; dr = data_mem_rdata; st = mem_read | mem_write;
                last_done_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #1;
        total++; if (all_out !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_read, mem_write, instr_mem_resp, data_mem_resp} !== 4'b0) begin
            bad++; $display("FAIL reset_idle: strobes/resp %b want 0000",
                            {mem_read, mem_write, instr_mem_resp, data_mem_resp});
        end
    endtask

    task automatic test_fetch_only();
        int rc; int e; logic ip, dp, st; logic [31:0] ir, dr;
        rd_q.push_back(32'h0000_0013);
        @(negedge clk);
        drive_group(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 3);
        e = exp_start;
        wait_done(rc, ip, dp, ir, dr, st);
        release_inputs();
        exp_ibuf = 32'h13;
        total++; if (rc !== e + 3) begin bad++; $display("FAIL fetch_latency: cycle %0d want %0d", rc, e + 3); end
        total++; if ({ip, dp} !== 2'b10) begin bad++; $display("FAIL fetch_resp: i/d %b want 10", {ip, dp}); end
        total++; if (ir !== exp_ibuf) begin bad++; $display("FAIL fetch_rdata: %h want %h", ir, exp_ibuf); end
        total++;
        if (log_q.size() != 1 || log_q[0].addr !== 32'h60 || log_q[0].rd !== 1'b1 || log_q[0].wr !== 1'b0 ||
            log_q[0].start != e || log_q[0].stable !== 1'b1) begin
            bad++; $display("FAIL fetch_txn: n=%0d addr=%h want 1 txn read of 00000060", log_q.size(),
                            (log_q.size() > 0) ? log_q[0].addr : 32'h0);
        end
        @(negedge clk);
        total++;
        if ({instr_mem_resp, data_mem_resp} !== 2'b00) begin
            bad++; $display("FAIL fetch_single_pulse: i/d %b want 00", {instr_mem_resp, data_mem_resp});
        end
    endtask

    task automatic test_load_fetch();
        int rc; int e; logic ip, dp, st; logic [31:0] ir, dr;
        rd_q.push_back(32'hDEAD_BEEF);
        rd_q.push_back(32'h00A0_0093);
        @(negedge clk);
        drive_group(1'b1, 32'h64, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 2, 2);
        e = exp_start;
        wait_done(rc, ip, dp, ir, dr, st);
        release_inputs();
        exp_ibuf = 32'h00A0_0093; exp_dbuf = 32'hDEAD_BEEF;
        total++; if (rc !== e + 4) begin bad++; $display("FAIL lf_latency: cycle %0d want %0d", rc, e + 4); end
        total++; if ({ip, dp, st} !== 3'b110) begin bad++; $display("FAIL lf_resp: i/d/strobe %b want 110", {ip, dp, st}); end
        total++;
        if (ir !== exp_ibuf || dr !== exp_dbuf) begin
            bad++; $display("FAIL lf_rdata: i=%h d=%h want %h %h", ir, dr, exp_ibuf, exp_dbuf);
        end
        total++;
        if (log_q.size() != 2 || log_q[0].addr !== 32'h104 || log_q[0].rd !== 1'b1 || log_q[0].mbe !== 4'hF ||
            log_q[1].addr !== 32'h64 || log_q[1].rd !== 1'b1 || log_q[1].start != e + 2) begin
            bad++; $display("FAIL lf_addr_seq: n=%0d want 00000104 then 00000064", log_q.size());
        end
    endtask

    task automatic test_store_fetch();
        int rc; int e; logic ip, dp, st; logic [31:0] ir, dr;
        @(negedge clk);
        drive_group(1'b1, 32'h68, 1'b0, 1'b1, 32'h200, 32'h1122_3344, 4'b0011, 1, 1);
        e = exp_start;
        wait_done(rc, ip, dp, ir, dr, st);
        release_inputs();
        exp_ibuf = mem_word(32'h68);
        total++; if (rc !== e + 2) begin bad++; $display("FAIL sf_latency: cycle %0d want %0d", rc, e + 2); end
        total++; if ({ip, dp} !== 2'b11) begin bad++; $display("FAIL sf_resp: i/d %b want 11", {ip, dp}); end
        total++; if (dr !== exp_dbuf) begin bad++; $display("FAIL sf_dbuf_kept: %h want %h", dr, exp_dbuf); end
        total++; if (ir !== exp_ibuf) begin bad++; $display("FAIL sf_ibuf: %h want %h", ir, exp_ibuf); end
        total++;
        if (log_q.size() != 2 || {log_q[0].addr, log_q[0].rd, log_q[0].wr, log_q[0].wdata, log_q[0].mbe} !==
            {32'h200, 1'b0, 1'b1, 32'h1122_3344, 4'b0011}) begin
            bad++; $display("FAIL sf_store_txn: n=%0d got %h/%h/%b want 00000200/11223344/0011", log_q.size(),
                            (log_q.size() > 0) ? log_q[0].addr : 32'h0,
                            (log_q.size() > 0) ? log_q[0].wdata : 32'h0,
                            (log_q.size() > 0) ? log_q[0].mbe : 4'h0);
        end
    endtask

    task automatic test_back_to_back();
        int rc; int e; logic ip, dp, st; logic [31:0] ir, dr; logic [31:0] a;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            drive_group(1'b1, a, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 2);
            e = exp_start;
            wait_done(rc, ip, dp, ir, dr, st);
            exp_ibuf = mem_word(a);
            total++;
            if (log_q.size() != 1 || log_q[0].addr !== a || log_q[0].start != e) begin
                bad++; $display("FAIL b2b_group%0d: n=%0d addr=%h start=%0d want %h start %0d", i, log_q.size(),
                                (log_q.size() > 0) ? log_q[0].addr : 32'h0,
                                (log_q.size() > 0) ? log_q[0].start : -1, a, e);
            end
            total++;
            if (rc !== e + 2 || ir !== exp_ibuf) begin
                bad++; $display("FAIL b2b_resp%0d: cycle %0d rdata %h want %0d %h", i, rc, ir, e + 2, exp_ibuf);
            end
        end
        release_inputs();
    endtask

    task automatic test_random();
        int rc; int e; int ld, li, gap, kind, n_exp, es;
        logic ip, dp, st, ni, nd, dr_, dw_, quiet, er, ew;
        logic [31:0] ir, dr, ia, da, wd, ea, ewd; logic [3:0] be, eb; logic [69:0] got;
        for (int k = 0; k < 40; k++) begin
            ni = 1'($urandom_range(0, 1)); kind = int'($urandom_range(0, 3));
            nd = (kind != 0); dr_ = (kind == 1 || kind == 3); dw_ = (kind >= 2);
            ia = $urandom; da = $urandom & 32'hFFFF_FFFC; wd = $urandom; be = 4'($urandom_range(0, 15));
            ld = int'($urandom_range(1, 4)); li = int'($urandom_range(1, 4)); gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            drive_group(ni, ia, dr_, dw_, da, wd, be, ld, li);
            if (!ni && !nd) begin
                quiet = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    if (mem_read || mem_write || instr_mem_resp || data_mem_resp) quiet = 1'b0;
                end
                total++; if (quiet !== 1'b1 || log_q.size() != 0) begin bad++; $display("FAIL rnd%0d_idle: activity with no request", k); end
                continue;
            end
            e = exp_start;
            wait_done(rc, ip, dp, ir, dr, st);
            release_inputs();
            if (nd && !dw_) exp_dbuf = mem_word(da);
            if (ni) exp_ibuf = mem_word(ia);
            total++;
            if (rc !== e + (nd ? ld : 0) + (ni ? li : 0)) begin
                bad++; $display("FAIL rnd%0d_latency: cycle %0d want %0d", k, rc, e + (nd ? ld : 0) + (ni ? li : 0));
            end
            total++; if ({ip, dp, st} !== {ni, nd, 1'b0}) begin bad++; $display("FAIL rnd%0d_resp: i/d/strobe %b want %b", k, {ip, dp, st}, {ni, nd, 1'b0}); end
            total++; if (ir !== exp_ibuf || dr !== exp_dbuf) begin bad++; $display("FAIL rnd%0d_bufs: %h %h want %h %h", k, ir, dr, exp_ibuf, exp_dbuf); end
            n_exp = (nd ? 1 : 0) + (ni ? 1 : 0);
            total++; if (log_q.size() != n_exp) begin bad++; $display("FAIL rnd%0d_ntxn: %0d want %0d", k, log_q.size(), n_exp); end
            for (int t = 0; t < log_q.size() && t < n_exp; t++) begin
                if (nd && t == 0) begin
                    ea = da; er = ~dw_; ew = dw_; ewd = dw_ ? wd : 32'h0; eb = dw_ ? be : 4'hF; es = e;
                    got = {log_q[t].addr, log_q[t].rd, log_q[t].wr, log_q[t].wr ? log_q[t].wdata : 32'h0, log_q[t].mbe};
                end else begin
                    ea = ia; er = 1'b1; ew = 1'b0; ewd = 32'h0; eb = 4'h0; es = e + (nd ? ld : 0);
                    got = {log_q[t].addr, log_q[t].rd, log_q[t].wr, log_q[t].wr ? log_q[t].wdata : 32'h0, 4'h0};
                end
                total++; if (got !== {ea, er, ew, ewd, eb}) begin bad++; $display("FAIL rnd%0d_txn%0d: %h want %h", k, t, got, {ea, er, ew, ewd, eb}); end
                total++;
                if (log_q[t].start != es || log_q[t].stable !== 1'b1) begin
                    bad++; $display("FAIL rnd%0d_dwell%0d: start %0d stable %b want %0d 1", k, t, log_q[t].start, log_q[t].stable, es);
                end
            end
        end
    endtask

    task automatic test_watchdog();
        int rc; int e;
        rc = -1;
        @(negedge clk);
        drive_group(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 30);
        e = exp_start;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cyc == e + 15) begin
                total++; if (wdog_err !== 1'b0) begin bad++; $display("FAIL wdog_early: %b want 0 after 15 waits", wdog_err); end
            end
            if (cyc == e + 16) begin
                total++; if (wdog_err !== WDOG_ON) begin bad++; $display("FAIL wdog_rise: %b want %b after 16 waits", wdog_err, WDOG_ON); end
            end
            if (instr_mem_resp || data_mem_resp) begin
                rc = cyc; last_done_cyc = cyc;
                exp_ibuf = mem_word(32'h400);
                total++; if (instr_mem_rdata !== exp_ibuf) begin bad++; $display("FAIL wdog_rdata: %h want %h", instr_mem_rdata, exp_ibuf); end
                break;
            end
        end
        release_inputs();
        total++; if (rc !== e + 30) begin bad++; $display("FAIL wdog_latency: cycle %0d want %0d", rc, e + 30); end
        @(negedge clk);
        total++; if (wdog_err !== WDOG_ON) begin bad++; $display("FAIL wdog_sticky: %b want %b", wdog_err, WDOG_ON); end
    endtask

    task automatic test_reset_mid();
        int rc; int e; logic ip, dp, st, seen, quiet; logic [31:0] ir, dr;
        @(negedge clk);
        drive_group(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 20, 1);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (mem_read) begin seen = 1'b1; break; end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rstmid_entry: no load strobe seen"); end
        #2 rst = 1'b0;
        #1;
        total++; if (all_out !== '0) begin bad++; $display("FAIL rstmid_async: outputs %h want 0", all_out); end
        @(negedge clk);
        release_inputs();
        lat_q.delete();
        man_resp = 1'b0; man_rdata = 32'hCAFE_F00D; manual = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1 man_resp = 1'b1;
        @(negedge clk);
        #1 man_resp = 1'b0;
        exp_ibuf = 32'h0; exp_dbuf = 32'h0;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (instr_mem_resp || data_mem_resp || mem_read || mem_write || data_mem_rdata !== 32'h0) quiet = 1'b0;
        end
        total++; if (quiet !== 1'b1) begin bad++; $display("FAIL rstmid_stale_resp: activity after stale mem_resp"); end
        manual = 1'b0;
        drive_group(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 1);
        e = exp_start;
        wait_done(rc, ip, dp, ir, dr, st);
        release_inputs();
        exp_ibuf = mem_word(32'h500);
        total++;
        if (rc !== e + 1 || {ip, dp} !== 2'b10 || ir !== exp_ibuf || dr !== exp_dbuf) begin
            bad++; $display("FAIL rstmid_recover: cycle %0d i/d %b rdata %h/%h want %0d 10 %h/%h",
                            rc, {ip, dp}, ir, dr, e + 1, exp_ibuf, exp_dbuf);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_load_fetch();
        test_store_fetch();
        test_back_to_back();
        test_random();
        test_watchdog();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
